reg_scan_reader: RTL and testbench



---
 rtl/reg_scan_pkg.sv | 15 +
 rtl/reg_scan_reader.sv | 159 +++++++++++++++
 tb/tb_reg_scan_reader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/reg_scan_pkg.sv
// Shared definitions for the register-scan debug reader and the register file.
package reg_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        HOLD,
        CHK,
        DONE
    } state_t;

    // Number of implemented registers; also used by the register file.
    localparam int unsigned NREGS_DEFAULT = 10;

endpackage

// File: rtl/reg_scan_reader.sv
// Debug read-out engine: walks a range of register indices through one
// read port and streams each captured value over valid/ready.
// Optional feature: define REG_SCAN_XOR_EN to append an XOR checksum word
// (CHK state) after the last register word.
module reg_scan_reader
    import reg_scan_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned D     = 4,
    parameter int unsigned NREGS = NREGS_DEFAULT
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         start,
    input  logic [D-1:0] first_reg,
    input  logic [D-1:0] last_reg,
    output logic [D-1:0] rd_addr,
    input  logic [W-1:0] rd_data,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         err
);

    state_t       state, state_nx;
    logic [D-1:0] idx, idx_nx;
    logic [D-1:0] last, last_nx;
    logic [D-1:0] rd_addr_nx;
    logic [W-1:0] out_data_nx;
    logic         out_valid_nx, out_last_nx, busy_nx, done_nx, err_nx;
    logic         handshake, bad_range;
`ifdef REG_SCAN_XOR_EN
    logic [W-1:0] acc, acc_nx;
`endif

    assign handshake = out_valid & out_ready;
    assign bad_range = (first_reg > last_reg) || (32'(last_reg) >= NREGS);

    // Next-state and next values for every registered output.
    // busy/done are registered so busy rises one edge after the accepted
    // start and done pulses on the edge that leaves DONE.
    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        last_nx      = last;
        rd_addr_nx   = rd_addr;
        out_data_nx  = out_data;
        out_valid_nx = out_valid;
        out_last_nx  = out_last;
        busy_nx      = busy;
        done_nx      = 1'b0;
        err_nx       = 1'b0;
`ifdef REG_SCAN_XOR_EN
        acc_nx       = acc;
`endif
        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (start) begin
                    if (bad_range) begin
                        err_nx = 1'b1;
                    end else begin
                        idx_nx     = first_reg;
                        rd_addr_nx = first_reg;
                        last_nx    = last_reg;
`ifdef REG_SCAN_XOR_EN
                        acc_nx     = '0;
`endif
                        state_nx   = READ;
                    end
                end
            end
            READ: begin
                out_data_nx  = rd_data;
                out_valid_nx = 1'b1;
                busy_nx      = 1'b1;
`ifdef REG_SCAN_XOR_EN
                out_last_nx  = 1'b0;
                acc_nx       = acc ^ rd_data;
`else
                out_last_nx  = (idx == last);
`endif
                state_nx     = HOLD;
            end
            HOLD: begin
                if (handshake) begin
                    out_valid_nx = 1'b0;
                    if (idx != last) begin
                        idx_nx     = idx + 1'b1;
                        rd_addr_nx = idx + 1'b1;
                        state_nx   = READ;
                    end else begin
`ifdef REG_SCAN_XOR_EN
                        state_nx = CHK;
`else
                        state_nx = DONE;
`endif
                    end
                end
            end
`ifdef REG_SCAN_XOR_EN
            // First CHK cycle loads the checksum word, then holds it until accepted.
            CHK: begin
                if (!out_valid) begin
                    out_data_nx  = acc;
                    out_valid_nx = 1'b1;
                    out_last_nx  = 1'b1;
                end else if (out_ready) begin
                    out_valid_nx = 1'b0;
                    state_nx     = DONE;
                end
            end
`endif
            DONE: begin
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight word at once.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            idx       <= '0;
            last      <= '0;
            rd_addr   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef REG_SCAN_XOR_EN
            acc       <= '0;
`endif
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            last      <= last_nx;
            rd_addr   <= rd_addr_nx;
            out_data  <= out_data_nx;
            out_valid <= out_valid_nx;
            out_last  <= out_last_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            err       <= err_nx;
`ifdef REG_SCAN_XOR_EN
            acc       <= acc_nx;
`endif
        end
    end

endmodule

// File: tb/tb_reg_scan_reader.sv
// Randomized bench for reg_scan_reader against a queue-based stream model.
module tb_reg_scan_reader;

    localparam int unsigned NR = 10;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       start;
    logic [3:0] first_reg, last_reg;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] out_data;
    logic       out_valid, out_ready, out_last, busy, done, err;

    logic [7:0] regs [0:NR-1];

    int checks = 0;
    int errors = 0;

    reg_scan_reader #(.W(8), .D(4), .NREGS(NR)) dut (
        .CLK(CLK), .Reset(Reset), .start(start),
        .first_reg(first_reg), .last_reg(last_reg),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    assign rd_data = (int'(rd_addr) < NR) ? regs[rd_addr] : 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Expected stream = regs[first..last] (+ XOR checksum when enabled).
    // Done lands 2*words+1 edges after start, plus one per stalled valid cycle.
    task automatic run_scan(input int unsigned first, input int unsigned last,
                            input int unsigned low_cycles, input int unsigned ready_pct,
                            input bit poke);
        logic [7:0]  exp_q[$];
        logic [7:0]  acc;
        logic [7:0]  prev_data;
        int unsigned stalls, lows, nwords, taken, exp_done;
        bit          seen_done, prev_stall;
        acc = '0; stalls = 0; lows = 0; taken = 0; seen_done = 0; prev_stall = 0;
        prev_data = '0;
        for (int unsigned i = first; i <= last; i++) begin
            exp_q.push_back(regs[i]);
            acc ^= regs[i];
        end
`ifdef REG_SCAN_XOR_EN
        exp_q.push_back(acc);
`endif
        nwords = exp_q.size();
        @(negedge CLK);
        start = 1'b1; first_reg = first[3:0]; last_reg = last[3:0]; out_ready = 1'b0;
        @(posedge CLK);
        for (int unsigned t = 0; t < 400 && !seen_done; t++) begin
            @(negedge CLK);
            start = poke && (t == 3);
            if (poke && t == 3) begin
                first_reg = 4'd0; last_reg = 4'd1;
            end
            exp_done = 2 * nwords + 1 + stalls;
            check("err_quiet", err, 0);
            check("busy", busy, (t >= 1) && (t < exp_done));
            check("done", done, t == exp_done);
            if (t <= 1) check("valid_start", out_valid, t == 1);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (done) seen_done = 1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", out_valid, 0);
                    out_ready = 1'b1;
                end else begin
                    check("data", out_data, exp_q[0]);
                    check("last", out_last, exp_q.size() == 1);
                    if (lows < low_cycles) begin
                        out_ready = 1'b0;
                        lows++;
                    end else begin
                        out_ready = ($urandom_range(99) < ready_pct);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        taken++;
                    end else begin
                        stalls++;
                    end
                end
                prev_stall = !out_ready;
                prev_data  = out_data;
            end else begin
                out_ready  = 1'($urandom_range(1));
                prev_stall = 0;
            end
        end
        start = 1'b0;
        check("done_seen", seen_done, 1);
        check("words", taken, nwords);
        @(negedge CLK);
        check_idle_outputs("after");
    endtask

    task automatic reject(input int unsigned first, input int unsigned last);
        @(negedge CLK);
        start = 1'b1; first_reg = first[3:0]; last_reg = last[3:0];
        @(negedge CLK);
        start = 1'b0;
        check("rej_err", err, 1);
        check("rej_busy", busy, 0);
        check("rej_valid", out_valid, 0);
        @(negedge CLK);
        check("rej_err_pulse", err, 0);
        check("rej_busy2", busy, 0);
        check("rej_valid2", out_valid, 0);
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < int'(NR); i++) regs[i] = 8'($urandom);
    endtask

    initial begin
        int unsigned f, l;
        Reset = 1'b1; start = 1'b0; first_reg = '0; last_reg = '0; out_ready = 1'b0;
        for (int i = 0; i < int'(NR); i++) regs[i] = 8'(8'h10 + i);
        repeat (2) @(negedge CLK);
        check("rst_addr", rd_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check_idle_outputs("rst");
        Reset = 1'b0;

        // Full directed scan, ready always high.
        run_scan(0, 9, 0, 100, 0);

        // Rejected starts.
        reject(5, 3);
        reject(0, 10);
        reject(0, 15);

        // Single register, ready held low for four valid cycles.
        run_scan(2, 2, 4, 100, 0);

        // Start pulsed mid-scan is ignored.
        randomize_regs();
        run_scan(1, 6, 0, 60, 1);

        // Reset while a word is being held.
        randomize_regs();
        @(negedge CLK);
        start = 1'b1; first_reg = 4'd3; last_reg = 4'd8; out_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        check("pre_rst_valid", out_valid, 1);
        Reset = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_addr", rd_addr, 0);
        check("arst_data", out_data, 0);
        check("arst_last", out_last, 0);
        @(negedge CLK);
        Reset = 1'b0;
        run_scan(3, 8, 0, 100, 0);

        // Random scans.
        for (int n = 0; n < 10; n++) begin
            randomize_regs();
            f = $urandom_range(NR - 1);
            l = $urandom_range(NR - 1, f);
            run_scan(f, l, $urandom_range(3), $urandom_range(100, 30), 1'($urandom_range(1)));
            if (n % 3 == 0) begin
                f = $urandom_range(NR - 1, 1);
                reject(f, $urandom_range(f - 1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
